// File: rtl/mapper_banked_pkg.sv
// Shared types for the banked ROM mapper: mapper type codes, block descriptor,
// mapper output bundle and the size-mask FSM encoding.
package mapper_banked_pkg;

  typedef enum logic [2:0] {
    MAPPER_NONE,
    MAPPER_ASCII8,
    MAPPER_ASCII16,
    MAPPER_KONAMI,
    MAPPER_KONAMI_SCC
  } mapper_typ_e;

  typedef struct packed {
    mapper_typ_e typ;
    logic [1:0]  offset_ram;
    logic [24:0] rom_size;
  } block_info_t;

  typedef struct packed {
    logic        ram_cs;
    logic [26:0] addr;
    logic        rnw;
  } mapper_out_t;

  typedef enum logic {
    MASK_INIT,
    MASK_RUN
  } mask_state_e;

  localparam logic [3:0]  MAX_MASK_K = 4'd8;
  localparam logic [26:0] ADDR_IDLE  = '1;

  // Each offset_ram step selects a 16 KB window of the physical RAM.
  function automatic logic [26:0] ram_base(input logic [1:0] off);
    return {11'b0, off, 14'b0};
  endfunction

endpackage

// File: rtl/mapper_banked_if.sv
// CPU-side bus seen by memory-mapped devices: address, write data and strobes.
interface cpu_bus_if;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        mreq;
  logic        rd;
  logic        wr;

  modport host_mp   (output addr, data, mreq, rd, wr);
  modport device_mp (input  addr, data, mreq, rd, wr);
endinterface

// File: rtl/mapper_banked_size_mask.sv
// Derives the bank-number mask from the ROM size: smallest power-of-two bank
// count covering the ROM (capped at 256 banks), recomputed when the size changes.
module mapper_size_mask
  import mapper_banked_pkg::*;
#(
  parameter int BANK_BITS = 13
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [24:0] rom_size,
  output logic [7:0]  mask,
  output logic        ready
);

  mask_state_e state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  mask_q, mask_d;
  logic [24:0] size_q, size_d;
  logic [4:0]  shAmt;
  logic [25:0] span;
  logic        sizeFits;

  assign shAmt    = 5'(k_q) + 5'(BANK_BITS);
  assign span     = 26'd1 << shAmt;
  assign sizeFits = span >= {1'b0, rom_size};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mask_d  = mask_q;
    size_d  = size_q;
    unique case (state_q)
      MASK_INIT: begin
        if (sizeFits || k_q == MAX_MASK_K) begin
          mask_d  = 8'((9'd1 << k_q) - 9'd1);
          size_d  = rom_size;
          state_d = MASK_RUN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      MASK_RUN: begin
        // The size captured on leaving INIT is the reference for change detection.
        if (rom_size != size_q) begin
          k_d     = 4'd0;
          state_d = MASK_INIT;
        end
      end
      default: state_d = MASK_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MASK_INIT;
      k_q     <= 4'd0;
      mask_q  <= 8'd0;
      size_q  <= 25'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      size_q  <= size_d;
    end
  end

  assign mask  = mask_q;
  assign ready = (state_q == MASK_RUN);

endmodule

// File: rtl/mapper_banked.sv
// ASCII-style banked ROM mapper: CPU pages map through writable bank registers
// onto a ROM image stored in external RAM at a selectable 16 KB offset.
module mapper_banked
  import mapper_banked_pkg::*;
#(
  parameter int          BANKS      = 4,
  parameter int          BANK_BITS  = 13,
  parameter int          FIRST_PAGE = 2,
  parameter logic [15:0] REG_BASE   = 16'h6000,
  parameter int          REG_SPAN   = 13,
  parameter mapper_typ_e MAP_TYPE   = MAPPER_ASCII8
) (
  input  logic            clk,
  input  logic            reset_n,
  cpu_bus_if.device_mp    cpu_bus,
  input  block_info_t     block_info,
  output mapper_out_t     out
);

  localparam int IDX_W = $clog2(BANKS);

  logic [7:0]       bank_q [BANKS];
  logic [7:0]       bank_d [BANKS];
  logic             wrArm_q, wrArm_d;
  logic [7:0]       mask;
  logic             ready;
  logic             cs;
  logic [31:0]      pageNum;
  logic             mapped;
  logic [IDX_W-1:0] slot;
  logic             regHit;
  logic [IDX_W-1:0] regIdx;
  logic [7:0]       effBank;
  logic [26:0]      romOff;
  logic [26:0]      ramAddr;
  logic             inRange;
  logic             rdHit;

  mapper_size_mask #(.BANK_BITS(BANK_BITS)) u_size_mask (
    .clk      (clk),
    .reset_n  (reset_n),
    .rom_size (block_info.rom_size),
    .mask     (mask),
    .ready    (ready)
  );

  assign cs      = (block_info.typ == MAP_TYPE) && cpu_bus.mreq && (cpu_bus.rd || cpu_bus.wr);
  assign pageNum = 32'(cpu_bus.addr[15:BANK_BITS]);
  assign mapped  = (pageNum >= 32'(FIRST_PAGE)) && (pageNum < 32'(FIRST_PAGE + BANKS));
  assign slot    = IDX_W'(pageNum - 32'(FIRST_PAGE));
  assign regHit  = cs && cpu_bus.wr && (cpu_bus.addr[15:REG_SPAN] == REG_BASE[15:REG_SPAN]);
  assign regIdx  = cpu_bus.addr[REG_SPAN-1 -: IDX_W];

  // Writes load only when armed by a prior cycle without an active write, so a
  // held strobe (including one spanning reset release) never reloads.
  always_comb begin
    bank_d  = bank_q;
    wrArm_d = !(cs && cpu_bus.wr);
    if (regHit && wrArm_q) begin
      bank_d[regIdx] = cpu_bus.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BANKS; i++) begin
        bank_q[i] <= 8'(i);
      end
      wrArm_q <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      wrArm_q <= wrArm_d;
    end
  end

  assign effBank = bank_q[slot] & mask;
  assign romOff  = (27'(effBank) << BANK_BITS) + 27'(cpu_bus.addr[BANK_BITS-1:0]);
  assign ramAddr = ram_base(block_info.offset_ram) + romOff;
  assign inRange = romOff < {2'b0, block_info.rom_size};
  assign rdHit   = cs && cpu_bus.rd && !cpu_bus.wr && mapped && ready && inRange;

  assign out.ram_cs = rdHit;
  assign out.addr   = rdHit ? ramAddr : ADDR_IDLE;
  assign out.rnw    = 1'b1;

endmodule

// File: doc/mapper_banked.md
MAPPER_BANKED -- requirements
Module: mapper_banked

Interface
REQ-001 SHALL have parameter BANKS, default 4, meaning number of switchable bank slots (power of two, 2..8).
REQ-002 SHALL have parameter BANK_BITS, default 13, meaning log2 of bank size in bytes (13 = 8 KB, 14 = 16 KB).
REQ-003 SHALL have parameter FIRST_PAGE, default 2, meaning CPU page index, in bank-size units, mapped to slot 0.
REQ-004 SHALL have parameter REG_BASE, default 16'h6000, meaning start of the bank-register write window.
REQ-005 SHALL have parameter REG_SPAN, default 13, meaning log2 of the register window size in bytes.
REQ-006 SHALL have parameter MAP_TYPE, default MAPPER_ASCII8, meaning the block_info.typ value that enables this block.
REQ-007 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-008 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have port cpu_bus  cpu_bus_if.device_mp  --  CPU addr[15:0], data[7:0], mreq, rd, wr.
REQ-010 SHALL have port block_info  input  struct  typ, offset_ram[1:0], rom_size[24:0].
REQ-011 SHALL have port out  mapper_out  --  ram_cs, addr[26:0], rnw.

Function
REQ-012 cs SHALL be (block_info.typ == MAP_TYPE) && mreq && (rd || wr).
REQ-013 slot = addr[15:BANK_BITS] - FIRST_PAGE; access SHALL be mapped only when 0 <= slot < BANKS, else ram_cs=0.
REQ-014 Register write SHALL occur when cs && wr && addr[15:REG_SPAN] == REG_BASE[15:REG_SPAN]; target index = addr[REG_SPAN-1 -: log2(BANKS)].
REQ-015 Register write SHALL be edge-qualified: only the first clk cycle of a continuous wr assertion loads; held wr SHALL NOT reload.
REQ-016 Loaded value SHALL be data[7:0]; new value visible to accesses from the next clk cycle (1-cycle latency).
REQ-017 Two writes to different indices on consecutive wr pulses SHALL both take effect; last write to an index wins.
REQ-018 Effective bank = bank[slot] & mask; out.addr = (offset_ram << 14) + (effective bank << BANK_BITS) + addr[BANK_BITS-1:0], 27-bit, carry discarded.
REQ-019 ram_cs SHALL be 1 only for mapped rd cycles in state RUN with (out.addr - (offset_ram<<14)) < rom_size; writes SHALL never assert ram_cs.
REQ-020 When ram_cs=0, out.addr SHALL be all ones; rnw SHALL be 1 at all times (ROM).
REQ-021 FSM states: INIT, RUN. INIT: counter k from 0, increment each cycle until (1 << (k+BANK_BITS)) >= rom_size or k==8; then mask=(1<<k)-1, go RUN.
REQ-022 rom_size == 0 SHALL yield mask=0, RUN, and ram_cs never asserted.
REQ-023 In RUN, a change of block_info.rom_size (registered compare) SHALL return FSM to INIT; mask recomputed.
REQ-024 During INIT, ram_cs=0, out.addr all ones; register writes SHALL still be accepted.
REQ-025 Read in the same cycle as a register write to the slot's own index SHALL use the old bank value.

Reset
REQ-026 reset_n low SHALL immediately set bank[i]=i, mask=0, k=0, FSM=INIT, write-edge tracker=0, stored rom_size=0.
REQ-027 Outputs under reset SHALL be ram_cs=0, addr=all ones, rnw=1.
REQ-028 Reset deassertion mid-access SHALL require a fresh wr edge before any register load.

Structure
REQ-029 MAPPER_* enum values, block_info and mapper_out types SHALL live in the shared mapper package.
REQ-030 Mask FSM SHALL be a sub-module mapper_size_mask (in: clk, reset_n, rom_size, BANK_BITS; out: mask[7:0], ready).

Verification
REQ-031 Reset, rom_size=64 KB, BANK_BITS=13 -> after INIT mask=8'h07; read 0x4000 -> addr 0x0000, 0x6000 -> 0x2000, ram_cs=1.
REQ-032 Write 0x05 to 0x6800 (index 1) -> read 0x6123 next cycle -> addr 0x0A123; same-cycle read -> old bank (0x2123).
REQ-033 wr held 4 cycles at 0x7000 while data changes 0x03 -> 0x06 -> bank[2]=0x03 only.
REQ-034 rom_size=40 KB, bank[0]=0x04 -> addr 0x8000 in range, ram_cs=1; bank[0]=0x05 -> 0xA000 >= rom_size, ram_cs=0, addr all ones.
REQ-035 offset_ram=2'b01, bank 0 default -> read 0x4000 -> addr 0x04000; read 0xC000 (unmapped slot) -> ram_cs=0.
REQ-036 Change rom_size 64 KB -> 256 KB in RUN -> ram_cs=0 during INIT, then mask=8'h1F; reset_n pulse mid-wr -> bank[i]=i, no load until next wr edge.
